// File: rtl/wb_stream_fifo.sv
// wb_stream_fifo: Wishbone slave with an RX FIFO (fabric -> host), a TX FIFO (host -> fabric),
// sticky status flags and an RX-level interrupt.
module wb_stream_fifo #(
    parameter int                    ADDR_WIDTH = 15,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEPTH_LOG2 = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 15'h0100
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic                  wb_we_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  irq
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [DEPTH_LOG2-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d, lvl_q, lvl_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d, rdata, status;
    logic                  ack_q, ack_d, irq_q, irq_d;
    logic                  rx_ovf_q, rx_ovf_d, rx_unf_q, rx_unf_d, tx_ovf_q, tx_ovf_d;

    // A transaction commits only on the first strobed cycle; the ack cycle masks the held strobe.
    logic       sel, start, rd_data, wr_data, ctrl_wr, flush_rx, flush_tx, clr;
    logic [2:0] off;
    assign sel      = wb_stb_i & wb_cyc_i & (wb_adr_i[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3]);
    assign start    = sel & ~ack_q;
    assign off      = wb_adr_i[2:0];
    assign rd_data  = start & ~wb_we_i & (off == 3'd0);
    assign wr_data  = start & wb_we_i & (off == 3'd0);
    assign ctrl_wr  = start & wb_we_i & (off == 3'd4);
    assign flush_rx = ctrl_wr & wb_dat_i[0];
    assign flush_tx = ctrl_wr & wb_dat_i[1];
    assign clr      = ctrl_wr & wb_dat_i[2];

    logic rx_empty, rx_full, tx_empty, tx_full, rx_pop, rx_push, tx_pop, tx_push;
    assign rx_empty = rx_cnt_q == '0;
    assign rx_full  = rx_cnt_q == FULL;
    assign tx_empty = tx_cnt_q == '0;
    assign tx_full  = tx_cnt_q == FULL;
    assign rx_pop   = rd_data & ~rx_empty & ~flush_rx;
    assign rx_push  = rx_valid & (~rx_full | rx_pop) & ~flush_rx;
    assign tx_pop   = tx_valid & tx_ready & ~flush_tx;
    assign tx_push  = wr_data & (~tx_full | (tx_valid & tx_ready)) & ~flush_tx;

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem_q[tx_rd_q];
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign irq      = irq_q;

    assign status = {{(DATA_WIDTH-7){1'b0}}, tx_ovf_q, rx_unf_q, rx_ovf_q, tx_full, tx_empty, rx_full, rx_empty};
    assign rdata  = (off == 3'd0) ? (rx_empty ? '0 : rx_mem_q[rx_rd_q]) :
                    (off == 3'd1) ? status :
                    (off == 3'd2) ? {{(DATA_WIDTH-CW){1'b0}}, rx_cnt_q} :
                    (off == 3'd3) ? {{(DATA_WIDTH-CW){1'b0}}, tx_cnt_q} :
                    (off == 3'd5) ? {{(DATA_WIDTH-CW){1'b0}}, lvl_q} : '0;

    always_comb begin
        ack_d    = start;
        dat_d    = (start & ~wb_we_i) ? rdata : '0;
        rx_wr_d  = flush_rx ? '0 : rx_wr_q + DEPTH_LOG2'(rx_push);
        rx_rd_d  = flush_rx ? '0 : rx_rd_q + DEPTH_LOG2'(rx_pop);
        rx_cnt_d = flush_rx ? '0 : rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        tx_wr_d  = flush_tx ? '0 : tx_wr_q + DEPTH_LOG2'(tx_push);
        tx_rd_d  = flush_tx ? '0 : tx_rd_q + DEPTH_LOG2'(tx_pop);
        tx_cnt_d = flush_tx ? '0 : tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        // New events take priority over a same-cycle clear.
        rx_ovf_d = (rx_valid & rx_full & ~rx_pop & ~flush_rx) | (rx_ovf_q & ~clr);
        rx_unf_d = (rd_data & rx_empty) | (rx_unf_q & ~clr);
        tx_ovf_d = (wr_data & tx_full & ~(tx_valid & tx_ready)) | (tx_ovf_q & ~clr);
        lvl_d    = (start & wb_we_i & (off == 3'd5)) ? wb_dat_i[CW-1:0] : lvl_q;
        irq_d    = (lvl_q != '0) && (rx_cnt_q >= lvl_q);
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            lvl_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_ovf_q <= rx_ovf_d;
            rx_unf_q <= rx_unf_d;
            tx_ovf_q <= tx_ovf_d;
            lvl_q    <= lvl_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wr_q] <= rx_data;
        if (tx_push) tx_mem_q[tx_wr_q] <= wb_dat_i;
    end
endmodule

// File: tb/tb_wb_stream_fifo.sv
// tb_wb_stream_fifo: directed and random stimulus against a queue-based model of both FIFOs,
// the sticky flags and the irq level rule.
module tb_wb_stream_fifo;
    localparam logic [14:0] BASE = 15'h0100;

    logic        clk = 1'b0, resetn = 1'b1;
    logic [14:0] wb_adr_i = '0;
    logic [15:0] wb_dat_i = '0, rx_data = '0;
    logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0, rx_valid = 1'b0, tx_ready = 1'b0;
    logic [15:0] wb_dat_o, tx_data;
    logic        wb_ack_o, tx_valid, irq;

    wb_stream_fifo dut (
        .clk(clk), .resetn(resetn), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [15:0] rxq[$], txq[$];
    bit          rx_ovf_m, rx_unf_m, tx_ovf_m;
    int          lvl_m;
    logic [15:0] rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] status_m();
        return {9'b0, tx_ovf_m, rx_unf_m, rx_ovf_m, txq.size() == 16, txq.size() == 0,
                rxq.size() == 16, rxq.size() == 0};
    endfunction

    function automatic void model_reset();
        rxq.delete(); txq.delete();
        rx_ovf_m = 0; rx_unf_m = 0; tx_ovf_m = 0; lvl_m = 0;
    endfunction

    // One clock edge; irq is the level rule applied to the state held before this edge.
    task automatic tick();
        bit ie;
        ie = (lvl_m != 0) && (rxq.size() >= lvl_m);
        check("tx_valid", tx_valid, txq.size() != 0);
        if (txq.size() != 0) check("tx_data", tx_data, txq[0]);
        @(posedge clk); #1;
        check("irq", irq, ie);
    endtask

    task automatic step(input bit rxv, input logic [15:0] rxd, input bit txr);
        rx_valid = rxv; rx_data = rxd; tx_ready = txr;
        tick();
        if (txr && txq.size() != 0) void'(txq.pop_front());
        if (rxv) begin
            if (rxq.size() < 16) rxq.push_back(rxd);
            else rx_ovf_m = 1;
        end
        rx_valid = 0; tx_ready = 0;
    endtask

    task automatic wb(input bit we, input bit [2:0] off, input logic [15:0] d,
                      input bit rxv, input logic [15:0] rxd, output logic [15:0] r);
        logic [15:0] e;
        bit pop, frx;
        pop = !we && off == 0 && rxq.size() != 0;
        frx = we && off == 4 && d[0];
        e = we ? 16'h0 : off == 0 ? (pop ? rxq[0] : 16'h0) : off == 1 ? status_m() :
            off == 2 ? 16'(rxq.size()) : off == 3 ? 16'(txq.size()) : off == 5 ? 16'(lvl_m) : 16'h0;
        wb_adr_i = BASE + 15'(off); wb_we_i = we; wb_dat_i = d; wb_stb_i = 1; wb_cyc_i = 1;
        rx_valid = rxv; rx_data = rxd;
        check("ack_pre", wb_ack_o, 0);
        tick();
        rx_valid = 0;
        if (we && off == 4 && d[2]) begin rx_ovf_m = 0; rx_unf_m = 0; tx_ovf_m = 0; end
        if (!we && off == 0) begin
            if (pop) void'(rxq.pop_front());
            else rx_unf_m = 1;
        end
        if (we && off == 0) begin
            if (txq.size() < 16) txq.push_back(d);
            else tx_ovf_m = 1;
        end
        if (frx) rxq.delete();
        if (we && off == 4 && d[1]) txq.delete();
        if (we && off == 5) lvl_m = int'(d[4:0]);
        if (rxv && !frx) begin
            if (rxq.size() < 16) rxq.push_back(rxd);
            else rx_ovf_m = 1;
        end
        check("ack", wb_ack_o, 1);
        r = wb_dat_o;
        check($sformatf("rdata_off%0d", off), r, e);
        tick();
        check("ack_once", wb_ack_o, 0);
        check("dat_idle", wb_dat_o, 0);
        wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", wb_ack_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_irq", irq, 0);
        check("rst_tx_valid", tx_valid, 0);
        resetn = 0;
        tick();
        wb(0, 1, 0, 0, 0, rd); check("status_rst", rd, 16'h0005);

        for (int i = 0; i < 6; i++) step(1, 16'h1111 + 16'(i), 0);
        for (int i = 0; i < 6; i++) begin wb(0, 0, 0, 0, 0, rd); check("rx_order", rd, 16'h1111 + 16'(i)); end
        wb(0, 2, 0, 0, 0, rd); check("rx_count_0", rd, 0);
        wb(0, 0, 0, 0, 0, rd); check("rx_underflow_data", rd, 0);
        wb(0, 1, 0, 0, 0, rd); check("rx_underflow_flag", rd[5], 1);

        for (int i = 0; i < 17; i++) step(1, 16'h2000 + 16'(i), 0);
        wb(0, 2, 0, 0, 0, rd); check("rx_count_16", rd, 16);
        wb(0, 1, 0, 0, 0, rd); check("rx_full", rd[1], 1); check("rx_overflow", rd[4], 1);
        wb(1, 4, 16'h0004, 0, 0, rd);
        wb(0, 1, 0, 0, 0, rd); check("sticky_clear", rd[5:4], 0);
        for (int i = 0; i < 16; i++) wb(0, 0, 0, 0, 0, rd);
        check("rx_last_kept", rd, 16'h200F);

        wb(1, 5, 16'd3, 0, 0, rd);
        for (int i = 0; i < 3; i++) step(1, 16'h4000 + 16'(i), 0);
        step(0, 0, 0);
        check("irq_rise", irq, 1);
        wb(0, 0, 0, 0, 0, rd);
        check("irq_drop", irq, 0);
        wb(1, 5, 0, 0, 0, rd);
        wb(1, 4, 16'h0001, 0, 0, rd);

        wb(1, 0, 16'hA5A5, 0, 0, rd);
        wb(1, 0, 16'h5A5A, 0, 0, rd);
        check("tx_valid_2", tx_valid, 1);
        check("tx_head", tx_data, 16'hA5A5);
        wb(0, 3, 0, 0, 0, rd); check("tx_count_2", rd, 2);
        step(0, 0, 1); check("tx_second", tx_data, 16'h5A5A);
        step(0, 0, 1); check("tx_drained", tx_valid, 0);

        for (int i = 0; i < 16; i++) step(1, 16'h3000 + 16'(i), 0);
        wb(0, 0, 0, 1, 16'h3AAA, rd); check("pop_push_oldest", rd, 16'h3000);
        wb(0, 2, 0, 0, 0, rd); check("pop_push_count", rd, 16);
        wb(0, 1, 0, 0, 0, rd); check("pop_push_no_ovf", rd[4], 0);
        wb(1, 4, 16'h0001, 1, 16'h3BBB, rd);
        wb(0, 2, 0, 0, 0, rd); check("flush_push_count", rd, 0);
        wb(0, 1, 0, 0, 0, rd); check("flush_push_no_ovf", rd[4], 0);

        step(1, 16'h7777, 0);
        wb_adr_i = BASE + 15'd8; wb_we_i = 0; wb_stb_i = 1; wb_cyc_i = 1;
        tick(); check("unsel_ack", wb_ack_o, 0); check("unsel_dat", wb_dat_o, 0);
        tick(); check("unsel_ack2", wb_ack_o, 0);
        wb_stb_i = 0; wb_cyc_i = 0;
        wb(0, 2, 0, 0, 0, rd); check("unsel_no_pop", rd, 1);

        wb(1, 0, 16'hBEEF, 0, 0, rd);
        wb_adr_i = BASE; wb_we_i = 0; wb_stb_i = 1; wb_cyc_i = 1;
        tick();
        check("mid_ack", wb_ack_o, 1);
        #2 resetn = 1; wb_stb_i = 0; wb_cyc_i = 0;
        #1;
        check("async_ack", wb_ack_o, 0);
        check("async_tx_valid", tx_valid, 0);
        model_reset();
        @(posedge clk); #1; resetn = 0;
        tick();
        wb(0, 1, 0, 0, 0, rd); check("status_after_rst", rd, 16'h0005);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: step(1'($urandom), 16'($urandom), 1'($urandom));
                4: wb(0, 3'($urandom), 0, 1'($urandom), 16'($urandom), rd);
                5: wb(0, 0, 0, 1'($urandom), 16'($urandom), rd);
                6: wb(1, 0, 16'($urandom), 1'($urandom), 16'($urandom), rd);
                7: wb(1, 4, 16'($urandom_range(0, 7)), 1'($urandom), 16'($urandom), rd);
                8: wb(1, 5, 16'($urandom_range(0, 20)), 0, 0, rd);
                default: wb(1, 3'($urandom_range(1, 3)), 16'($urandom), 0, 0, rd);
            endcase
        end
        wb(0, 1, 0, 0, 0, rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
